// File: rtl/i2c_pkg.sv
// Shared I2C definitions: field widths, FSM state encoding and the address
// match helper used by the target.
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    RX_DATA  = 3'd3,
    RX_ACK   = 3'd4,
    TX_DATA  = 3'd5,
    TX_ACK   = 3'd6,
    IGNORE   = 3'd7
  } i2c_state_e;

  // The general-call address (0) never matches, even if configured as own address.
  function automatic logic addr_hit(input logic [I2C_ADDR_W-1:0] rx_addr,
                                    input logic [I2C_ADDR_W-1:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_slave_if.sv
// Application-side interface of the I2C target: received bytes, read-data
// requests and transaction status.
interface i2c_slave_if;
  import i2c_pkg::*;

  logic [I2C_BYTE_W-1:0] rx_data;
  logic                  rx_valid;
  logic [I2C_BYTE_W-1:0] tx_data;
  logic                  tx_req;
  logic                  rw;
  logic                  busy;
  logic                  stop_det;
  logic                  nack_det;

  modport slave (
    output rx_data, rx_valid, tx_req, rw, busy, stop_det, nack_det,
    input  tx_data
  );

  modport master (
    input  rx_data, rx_valid, tx_req, rw, busy, stop_det, nack_det,
    output tx_data
  );

endinterface

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one I2C line with rise/fall detection.
// Optional glitch filter enabled by defining I2C_SLAVE_GLITCH_FILTER_EN:
// the filtered level only follows the line after FILTER_DEPTH equal samples.
module i2c_line_sync #(
  parameter int FILTER_DEPTH = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic s1_q;
  logic s2_q;
  logic prev_q;
  logic level_s;

  // Synchroniser; resets to the idle (pulled-up) bus level.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= line_i;
      s2_q <= s1_q;
    end
  end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILTER_DEPTH + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             filt_q;
  logic             filt_d;

  // Count consecutive samples that disagree with the filtered level.
  always_comb begin
    cnt_d  = cnt_q;
    filt_d = filt_q;
    if (s2_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_DEPTH - 1)) begin
        filt_d = s2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Filter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      filt_q <= filt_d;
    end
  end

  assign level_s = filt_q;
`else
  logic unused_depth;
  assign unused_depth = (FILTER_DEPTH > 0);
  assign level_s      = s2_q;
`endif

  // Previous level for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= level_s;
    end
  end

  assign level_o = level_s;
  assign rise_o  = level_s & ~prev_q;
  assign fall_o  = ~level_s & prev_q;

endmodule

// File: rtl/i2c_slave.sv
// I2C target with one fixed 7-bit address. Oversamples SCL/SDA, detects
// START/Sr/STOP, ACKs its address and every written byte, and serves read
// bytes fetched through tx_req/tx_data. SDA is open-drain; no clock stretching.
// Optional glitch filter on both lines: define I2C_SLAVE_GLITCH_FILTER_EN.
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_W-1:0] ADDRESS      = 7'h42,
  parameter int                    FILTER_DEPTH = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  inout  wire        sda,
  i2c_slave_if.slave app
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_s, stop_s;

  i2c_state_e            state_q, state_d;
  logic [3:0]            bit_cnt_q, bit_cnt_d;
  logic [I2C_ADDR_W-1:0] shift_q, shift_d;
  logic [I2C_BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic                  match_q, match_d;
  logic                  sda_oe_q, sda_oe_d;
  logic [I2C_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  tx_req_q, tx_req_d;
  logic                  rw_q, rw_d;
  logic                  busy_q, busy_d;
  logic                  stop_det_q, stop_det_d;
  logic                  nack_det_q, nack_det_d;

  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_scl_sync (
    .clk(clk), .reset(reset), .line_i(scl),
    .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
  );

  i2c_line_sync #(.FILTER_DEPTH(FILTER_DEPTH)) u_sda_sync (
    .clk(clk), .reset(reset), .line_i(sda),
    .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
  );

  assign start_s = sda_fall & scl_lvl;
  assign stop_s  = sda_rise & scl_lvl;

  // Next-state logic: bus conditions first, then SCL-edge handling per state.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    match_d    = match_q;
    sda_oe_d   = sda_oe_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    rw_d       = rw_q;
    busy_d     = busy_q;
    stop_det_d = 1'b0;
    nack_det_d = 1'b0;

    if (stop_s) begin
      state_d    = IDLE;
      stop_det_d = 1'b1;
      busy_d     = 1'b0;
      sda_oe_d   = 1'b0;
      bit_cnt_d  = 4'd0;
    end else if (start_s) begin
      state_d   = ADDR;
      bit_cnt_d = 4'd0;
      busy_d    = 1'b0;
      sda_oe_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          sda_oe_d = 1'b0;
        end
        ADDR: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              match_d = addr_hit(shift_q, ADDRESS);
            end else begin
              match_d = match_q;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            bit_cnt_d = 4'd0;
            if (match_q) begin
              sda_oe_d = 1'b1;
              busy_d   = 1'b1;
              rw_d     = shift_q[0];
              state_d  = ADDR_ACK;
            end else begin
              state_d = IGNORE;
            end
          end else begin
            state_d = ADDR;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            if (rw_q) begin
              tx_req_d = 1'b1;
              state_d  = TX_DATA;
            end else begin
              state_d = RX_DATA;
            end
          end else begin
            state_d = ADDR_ACK;
          end
        end
        RX_DATA: begin
          if (scl_rise) begin
            shift_d   = {shift_q[I2C_ADDR_W-2:0], sda_lvl};
            bit_cnt_d = bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd7) begin
              rx_data_d  = {shift_q, sda_lvl};
              rx_valid_d = 1'b1;
            end else begin
              rx_valid_d = 1'b0;
            end
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            sda_oe_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = RX_ACK;
          end else begin
            state_d = RX_DATA;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = RX_DATA;
          end else begin
            state_d = RX_ACK;
          end
        end
        TX_DATA: begin
          // tx_data is valid in the cycle tx_req is high: load and drive the MSB.
          if (tx_req_q) begin
            sda_oe_d   = ~app.tx_data[7];
            tx_shift_d = {app.tx_data[6:0], 1'b0};
            bit_cnt_d  = 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              state_d   = TX_ACK;
            end else begin
              sda_oe_d   = ~tx_shift_q[7];
              tx_shift_d = {tx_shift_q[6:0], 1'b0};
              bit_cnt_d  = bit_cnt_q + 4'd1;
            end
          end else begin
            state_d = TX_DATA;
          end
        end
        TX_ACK: begin
          if (scl_rise && sda_lvl) begin
            nack_det_d = 1'b1;
            sda_oe_d   = 1'b0;
            state_d    = IGNORE;
          end else if (scl_fall) begin
            tx_req_d  = 1'b1;
            bit_cnt_d = 4'd0;
            state_d   = TX_DATA;
          end else begin
            state_d = TX_ACK;
          end
        end
        IGNORE: begin
          sda_oe_d = 1'b0;
        end
        default: begin
          state_d  = IDLE;
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 4'd0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      match_q    <= 1'b0;
      sda_oe_q   <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      rw_q       <= 1'b0;
      busy_q     <= 1'b0;
      stop_det_q <= 1'b0;
      nack_det_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      match_q    <= match_d;
      sda_oe_q   <= sda_oe_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      tx_req_q   <= tx_req_d;
      rw_q       <= rw_d;
      busy_q     <= busy_d;
      stop_det_q <= stop_det_d;
      nack_det_q <= nack_det_d;
    end
  end

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  assign app.rx_data  = rx_data_q;
  assign app.rx_valid = rx_valid_q;
  assign app.tx_req   = tx_req_q;
  assign app.rw       = rw_q;
  assign app.busy     = busy_q;
  assign app.stop_det = stop_det_q;
  assign app.nack_det = nack_det_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Directed testbench for i2c_slave: bit-banged I2C master on scl/sda with
// event counters on the application interface.
module tb_i2c_slave;
  import i2c_pkg::*;

  localparam int Q = 8;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic reset;
  logic scl;
  logic m_sda_low;
  wire  sda;

  int checks = 0;
  int errors = 0;
  int rx_cnt, stop_cnt, txreq_cnt, nack_cnt, drive_cnt;
  logic [7:0] last_rx;
  logic busy_seen;

  i2c_slave_if app_if();

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDRESS(7'h42), .FILTER_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .scl(scl), .sda(sda), .app(app_if.slave)
  );

  always #5 clk = ~clk;

  // Event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (app_if.rx_valid) begin
      rx_cnt  = rx_cnt + 1;
      last_rx = app_if.rx_data;
    end
    if (app_if.stop_det) stop_cnt = stop_cnt + 1;
    if (app_if.tx_req)   txreq_cnt = txreq_cnt + 1;
    if (app_if.nack_det) nack_cnt = nack_cnt + 1;
    if (!m_sda_low && sda === 1'b0) drive_cnt = drive_cnt + 1;
    if (app_if.busy) busy_seen = 1'b1;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clear_counters();
    rx_cnt = 0; stop_cnt = 0; txreq_cnt = 0; nack_cnt = 0; drive_cnt = 0;
    last_rx = 8'h00; busy_seen = 1'b0;
  endtask

  task automatic i2c_start();
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; wait_q();
    scl = 1'b1;       wait_q();
    m_sda_low = 1'b0; wait_q();
  endtask

  task automatic send_bit(input logic b, input logic glitch);
    m_sda_low = ~b; wait_q();
    scl = 1'b1;     wait_q();
    if (glitch) begin
      scl = 1'b0; @(negedge clk);
      scl = 1'b1; repeat (Q - 1) @(negedge clk);
    end else begin
      wait_q();
    end
    scl = 1'b0;     wait_q();
  endtask

  task automatic recv_bit(output logic b);
    m_sda_low = 1'b0; wait_q();
    scl = 1'b1;       wait_q();
    b = (sda === 1'b0) ? 1'b0 : 1'b1;
    wait_q();
    scl = 1'b0;       wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input int glitch_bit, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], (i == glitch_bit));
    recv_bit(ack);
  endtask

  task automatic read_byte(input logic master_nack, input logic [7:0] next_tx, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
      if (i == 7) app_if.tx_data = next_tx;
    end
    send_bit(master_nack, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; scl = 1'b1; m_sda_low = 1'b0; app_if.tx_data = 8'h00;
    repeat (5) @(negedge clk);
    checks++; if (app_if.rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", app_if.rx_data); end
    checks++; if ({app_if.rx_valid, app_if.tx_req, app_if.rw, app_if.busy, app_if.stop_det, app_if.nack_det} !== 6'b000000) begin
      errors++; $display("FAIL reset_flags got %b want 000000", {app_if.rx_valid, app_if.tx_req, app_if.rw, app_if.busy, app_if.stop_det, app_if.nack_det});
    end
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL reset_sda got %b want 1", sda); end
    reset = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_write();
    logic ack;
    clear_counters();
    i2c_start();
    write_byte(8'h84, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_addr_ack got %b want 0", ack); end
    checks++; if (app_if.busy !== 1'b1) begin errors++; $display("FAIL wr_busy got %b want 1", app_if.busy); end
    checks++; if (app_if.rw !== 1'b0) begin errors++; $display("FAIL wr_rw got %b want 0", app_if.rw); end
    write_byte(8'hA5, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL wr_data_ack got %b want 0", ack); end
    i2c_stop();
    repeat (6) @(negedge clk);
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL wr_rx_cnt got %0d want 1", rx_cnt); end
    checks++; if (last_rx !== 8'hA5) begin errors++; $display("FAIL wr_rx_data got %h want a5", last_rx); end
    checks++; if (stop_cnt !== 1) begin errors++; $display("FAIL wr_stop_cnt got %0d want 1", stop_cnt); end
    checks++; if (app_if.busy !== 1'b0) begin errors++; $display("FAIL wr_busy_end got %b want 0", app_if.busy); end
  endtask

  task automatic test_wrong_addr();
    logic ack;
    clear_counters();
    i2c_start();
    write_byte(8'h86, -1, ack);
    checks++; if (ack !== 1'b1) begin errors++; $display("FAIL wa_addr_ack got %b want 1", ack); end
    write_byte(8'hFF, -1, ack);
    i2c_stop();
    repeat (6) @(negedge clk);
    checks++; if (drive_cnt !== 0) begin errors++; $display("FAIL wa_sda_driven got %0d want 0", drive_cnt); end
    checks++; if (rx_cnt !== 0) begin errors++; $display("FAIL wa_rx_cnt got %0d want 0", rx_cnt); end
    checks++; if (busy_seen !== 1'b0) begin errors++; $display("FAIL wa_busy got %b want 0", busy_seen); end
    checks++; if (stop_cnt !== 1) begin errors++; $display("FAIL wa_stop_cnt got %0d want 1", stop_cnt); end
  endtask

  task automatic test_read();
    logic ack;
    logic [7:0] d;
    clear_counters();
    app_if.tx_data = 8'h3C;
    i2c_start();
    write_byte(8'h85, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rd_addr_ack got %b want 0", ack); end
    checks++; if (app_if.rw !== 1'b1) begin errors++; $display("FAIL rd_rw got %b want 1", app_if.rw); end
    read_byte(1'b0, 8'hC3, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rd_byte0 got %h want 3c", d); end
    read_byte(1'b1, 8'h00, d);
    checks++; if (d !== 8'hC3) begin errors++; $display("FAIL rd_byte1 got %h want c3", d); end
    i2c_stop();
    repeat (6) @(negedge clk);
    checks++; if (txreq_cnt !== 2) begin errors++; $display("FAIL rd_tx_req got %0d want 2", txreq_cnt); end
    checks++; if (nack_cnt !== 1) begin errors++; $display("FAIL rd_nack got %0d want 1", nack_cnt); end
    checks++; if (stop_cnt !== 1) begin errors++; $display("FAIL rd_stop_cnt got %0d want 1", stop_cnt); end
  endtask

  task automatic test_repeated_start();
    logic ack;
    logic [7:0] d;
    clear_counters();
    app_if.tx_data = 8'h5A;
    i2c_start();
    write_byte(8'h84, -1, ack);
    write_byte(8'h10, -1, ack);
    checks++; if (last_rx !== 8'h10) begin errors++; $display("FAIL sr_rx_data got %h want 10", last_rx); end
    i2c_start();
    write_byte(8'h85, -1, ack);
    checks++; if (ack !== 1'b0) begin errors++; $display("FAIL sr_addr_ack got %b want 0", ack); end
    checks++; if (app_if.rw !== 1'b1) begin errors++; $display("FAIL sr_rw got %b want 1", app_if.rw); end
    read_byte(1'b1, 8'h00, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL sr_read got %h want 5a", d); end
    checks++; if (stop_cnt !== 0) begin errors++; $display("FAIL sr_stop_early got %0d want 0", stop_cnt); end
    i2c_stop();
    repeat (6) @(negedge clk);
    checks++; if (stop_cnt !== 1) begin errors++; $display("FAIL sr_stop_cnt got %0d want 1", stop_cnt); end
    checks++; if (rx_cnt !== 1) begin errors++; $display("FAIL sr_rx_cnt got %0d want 1", rx_cnt); end
  endtask

  task automatic test_reset_mid_ack();
    logic ack;
    clear_counters();
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h84 >> i), 1'b0);
    m_sda_low = 1'b0;
    @(negedge clk);
    checks++; if (sda !== 1'b0) begin errors++; $display("FAIL rm_ack_held got %b want 0", sda); end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (sda !== 1'b1) begin errors++; $display("FAIL rm_sda_release got %b want 1", sda); end
    checks++; if ({app_if.rx_data, app_if.busy, app_if.rw} !== 10'd0) begin
      errors++; $display("FAIL rm_outputs got %h want 0", {app_if.rx_data, app_if.busy, app_if.rw});
    end
    reset = 1'b0;
    scl = 1'b1;
    wait_q();
    // Back-to-back transfer from IDLE after the abort.
    clear_counters();
    i2c_start();
    write_byte(8'h84, -1, ack);
    write_byte(8'h77, -1, ack);
    i2c_stop();
    repeat (6) @(negedge clk);
    checks++; if (last_rx !== 8'h77 || rx_cnt !== 1) begin errors++; $display("FAIL rm_after_write got %h/%0d want 77/1", last_rx, rx_cnt); end
  endtask

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
  task automatic test_glitch();
    logic ack;
    clear_counters();
    i2c_start();
    write_byte(8'h84, -1, ack);
    write_byte(8'h5A, 3, ack);
    i2c_stop();
    repeat (8) @(negedge clk);
    checks++; if (last_rx !== 8'h5A || rx_cnt !== 1) begin errors++; $display("FAIL gl_rx got %h/%0d want 5a/1", last_rx, rx_cnt); end
  endtask
`endif

  initial begin
    clear_counters();
    test_reset();
    test_write();
    test_wrong_addr();
    test_read();
    test_repeated_start();
    test_reset_mid_ack();
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    test_glitch();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
